// File: rtl/math_unit_seq.sv
// Registered add/sub/logic unit with persistent C/V/N/Z flags and a valid/ready handshake.
// Define MATH_UNIT_MUL_EN to build in the iterative shift-add multiplier for op 111.
module math_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

`ifdef MATH_UNIT_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t state, state_next;

  // Single-cycle ALU, evaluated on the request inputs at the accept edge.
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_err;

  always_comb begin
    b_eff     = b;
    cin       = 1'b0;
    alu_res   = '0;
    alu_flags = flags;
    alu_err   = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin b_eff = ~b; cin = 1'b1;     end
      OP_ADC:         begin b_eff = b;  cin = flags[3]; end
      OP_SBC:         begin b_eff = ~b; cin = flags[3]; end
      default:        begin b_eff = b;  cin = 1'b0;     end
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
        alu_res   = (op == OP_CMP) ? a : sum[WIDTH-1:0];
        // CMP takes N/Z from the difference even though result carries a.
        alu_flags = {sum[WIDTH],
                     (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]),
                     sum[WIDTH-1],
                     (sum[WIDTH-1:0] == '0)};
      end
      OP_AND: begin
        alu_res   = a & b;
        alu_flags = {2'b00, alu_res[WIDTH-1], (alu_res == '0)};
      end
      OP_OR: begin
        alu_res   = a | b;
        alu_flags = {2'b00, alu_res[WIDTH-1], (alu_res == '0)};
      end
      default: begin
        alu_res   = '0;
        alu_flags = flags;
        alu_err   = 1'b1;
      end
    endcase
  end

`ifdef MATH_UNIT_MUL_EN
  logic [WIDTH-1:0]   a_q;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     upper_sum;
  logic               mul_done;

  // acc = {partial high, multiplier bits still to consume}; one bit retires per cycle.
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_done  = (count == CW'(WIDTH));
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef MATH_UNIT_MUL_EN
          state_next = (op == OP_MUL) ? S_MUL : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef MATH_UNIT_MUL_EN
      S_MUL:   if (mul_done) state_next = S_DONE;
`endif
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
`ifdef MATH_UNIT_MUL_EN
      a_q       <= '0;
      count     <= '0;
      acc       <= '0;
`endif
    end else begin
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef MATH_UNIT_MUL_EN
            if (op == OP_MUL) begin
              a_q   <= a;
              count <= '0;
              acc   <= {{WIDTH{1'b0}}, b};
            end else begin
              result <= alu_res;
              flags  <= alu_flags;
              err    <= alu_err;
            end
`else
            result <= alu_res;
            flags  <= alu_flags;
            err    <= alu_err;
`endif
          end
        end
`ifdef MATH_UNIT_MUL_EN
        S_MUL: begin
          if (mul_done) begin
            result <= acc[WIDTH-1:0];
            flags  <= {(acc[2*WIDTH-1:WIDTH] != '0), (acc[2*WIDTH-1:WIDTH] != '0),
                       acc[WIDTH-1], (acc[WIDTH-1:0] == '0)};
            err    <= 1'b0;
          end else begin
            count <= count + 1'b1;
            acc   <= {upper_sum, acc[WIDTH-1:1]};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_math_unit_seq.sv
// Directed self-checking bench for math_unit_seq (WIDTH=8); MUL tests follow MATH_UNIT_MUL_EN.
module tb_math_unit_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  int passed = 0;
  int total  = 0;

  math_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  // Drives one request and returns the number of cycles from accept to out_valid (capped).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    total++; if ({out_valid, in_ready, result, flags, err} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset_init got v=%b r=%b res=%h f=%b e=%b want v=0 r=1 res=00 f=0000 e=0",
               out_valid, in_ready, result, flags, err); else passed++;
    issue(3'b000, 8'hFF, 8'h01, lat);
    total++; if (flags !== 4'b1001) $display("FAIL reset_pre_flags got %b want 1001", flags); else passed++;
    pop();
    @(negedge clk);
`ifdef MATH_UNIT_MUL_EN
    in_valid = 1'b1; op = 3'b111; a = 8'h03; b = 8'h05;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    in_valid = 1'b1; op = 3'b000; a = 8'h7F; b = 8'h01;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if ({out_valid, in_ready, result, flags, err} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset_mid got v=%b r=%b res=%h f=%b e=%b want v=0 r=1 res=00 f=0000 e=0",
               out_valid, in_ready, result, flags, err); else passed++;
    repeat (12) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_discard got v=%b want 0", out_valid); else passed++;
    issue(3'b000, 8'h01, 8'h01, lat);
    total++; if (result !== 8'h02) $display("FAIL reset_add got %h want 02", result); else passed++;
    pop();
  endtask

  task automatic test_add();
    int lat;
    issue(3'b000, 8'h7F, 8'h01, lat);
    total++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else passed++;
    total++; if (result !== 8'h80) $display("FAIL add_result got %h want 80", result); else passed++;
    total++; if (flags !== 4'b0110) $display("FAIL add_flags got %b want 0110", flags); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL add_in_ready got %b want 0", in_ready); else passed++;
    pop();
  endtask

  task automatic test_sub_sbc();
    int lat;
    issue(3'b001, 8'h05, 8'h05, lat);
    total++; if ({result, flags} !== {8'h00, 4'b1001}) $display("FAIL sub_zero got %h/%b want 00/1001", result, flags); else passed++;
    pop();
    issue(3'b011, 8'h00, 8'h00, lat);
    total++; if ({result, flags} !== {8'h00, 4'b1001}) $display("FAIL sbc_c1 got %h/%b want 00/1001", result, flags); else passed++;
    pop();
    issue(3'b100, 8'h00, 8'h01, lat);
    total++; if ({result, flags} !== {8'h00, 4'b0010}) $display("FAIL cmp got %h/%b want 00/0010", result, flags); else passed++;
    pop();
    issue(3'b011, 8'h10, 8'h01, lat);
    total++; if ({result, flags} !== {8'h0E, 4'b1000}) $display("FAIL sbc_c0 got %h/%b want 0e/1000", result, flags); else passed++;
    pop();
    issue(3'b010, 8'hFF, 8'h00, lat);
    total++; if ({result, flags} !== {8'h00, 4'b1001}) $display("FAIL adc_c1 got %h/%b want 00/1001", result, flags); else passed++;
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(3'b101, 8'hF0, 8'h3C, lat);
    total++; if ({result, flags} !== {8'h30, 4'b0000}) $display("FAIL and got %h/%b want 30/0000", result, flags); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'h30})
        $display("FAIL bp_hold%0d got v=%b r=%b res=%h want v=1 r=0 res=30", i, out_valid, in_ready, result); else passed++;
    end
    pop();
    total++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h30})
      $display("FAIL bp_release got v=%b r=%b res=%h want v=0 r=1 res=30", out_valid, in_ready, result); else passed++;
    issue(3'b110, 8'h80, 8'h01, lat);
    total++; if ({result, flags} !== {8'h81, 4'b0010}) $display("FAIL or got %h/%b want 81/0010", result, flags); else passed++;
    pop();
  endtask

  task automatic test_mul();
    int lat;
`ifdef MATH_UNIT_MUL_EN
    issue(3'b111, 8'h10, 8'h10, lat);
    total++; if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else passed++;
    total++; if ({result, flags, err} !== {8'h00, 4'b1101, 1'b0})
      $display("FAIL mul_ovf got %h/%b/%b want 00/1101/0", result, flags, err); else passed++;
    pop();
    issue(3'b111, 8'h0F, 8'h03, lat);
    total++; if ({result, flags} !== {8'h2D, 4'b0000}) $display("FAIL mul_small got %h/%b want 2d/0000", result, flags); else passed++;
    pop();
    issue(3'b111, 8'hFF, 8'hFF, lat);
    total++; if ({result, flags} !== {8'h01, 4'b1100}) $display("FAIL mul_max got %h/%b want 01/1100", result, flags); else passed++;
    pop();
`else
    // Flags left at 0010 by the preceding OR must survive the illegal op.
    issue(3'b111, 8'h05, 8'h06, lat);
    total++; if (lat !== 1) $display("FAIL mul_off_latency got %0d want 1", lat); else passed++;
    total++; if ({result, flags, err} !== {8'h00, 4'b0010, 1'b1})
      $display("FAIL mul_off got %h/%b/%b want 00/0010/1", result, flags, err); else passed++;
    pop();
    issue(3'b000, 8'h01, 8'h02, lat);
    total++; if ({result, err} !== {8'h03, 1'b0}) $display("FAIL err_clear got %h/%b want 03/0", result, err); else passed++;
    pop();
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; a = 8'h03; b = 8'h04; out_ready = 1'b1;
    @(posedge clk);
    #1 op = 3'b001; a = 8'h09; b = 8'h03;
    @(negedge clk);
    total++; if ({out_valid, result} !== {1'b1, 8'h07}) $display("FAIL b2b_first got v=%b res=%h want v=1 res=07", out_valid, result); else passed++;
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== {1'b0, 1'b1}) $display("FAIL b2b_gap got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if ({out_valid, result, flags} !== {1'b1, 8'h06, 4'b1000})
      $display("FAIL b2b_second got v=%b res=%h f=%b want v=1 res=06 f=1000", out_valid, result, flags); else passed++;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbc();
    test_backpressure();
    test_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
